// File: rtl/counter_pkg.sv
// Shared types and constants for the modulo-N counter family.
package counter_pkg;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_SAT = 1'b1
    } counter_state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_next.sv
// Combinational step logic: the value one count away from y in the
// requested direction, wrapping inside 0..MODULUS-1.
module counter_next
    import counter_pkg::*;
#(
    parameter int WIDTH   = 2,
    parameter int MODULUS = 4
) (
    input  logic [WIDTH-1:0] y,
    input  logic             up,
    output logic [WIDTH-1:0] y_next,
    output logic             at_terminal,
    output logic             wrap_event
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    always_comb begin
        at_terminal = 1'b0;
        y_next      = y;
        case (up)
            DIR_UP: begin
                at_terminal = (y == MAX_VAL);
                y_next      = at_terminal ? '0 : y + WIDTH'(1);
            end
            DIR_DOWN: begin
                at_terminal = (y == '0);
                y_next      = at_terminal ? MAX_VAL : y - WIDTH'(1);
            end
        endcase
        wrap_event = at_terminal;
    end

endmodule

// File: rtl/counter_mod_n.sv
// Parametrised modulo-N up/down counter with clear, load, terminal count,
// wrap pulse and an optional saturating mode.
module counter_mod_n
    import counter_pkg::*;
#(
    parameter int WIDTH    = 2,
    parameter int MODULUS  = 4,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] y,
    output logic             tc,
    output logic             wrapped,
    output logic             sat
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam bit               SAT_EN  = (SATURATE != 0);

    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
        $error("counter_mod_n: MODULUS %0d is illegal for WIDTH %0d", MODULUS, WIDTH);
    end

    counter_state_t   state, state_d;
    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] y_step;
    logic [WIDTH-1:0] load_clamped;
    logic             wrapped_d;
    logic             at_terminal;
    logic             wrap_event;

    counter_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .y           (y),
        .up          (up),
        .y_next      (y_step),
        .at_terminal (at_terminal),
        .wrap_event  (wrap_event)
    );

    assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    assign tc           = en && at_terminal;
    assign sat          = (state == ST_SAT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y       <= '0;
            state   <= ST_RUN;
            wrapped <= 1'b0;
        end else begin
            y       <= y_d;
            state   <= state_d;
            wrapped <= wrapped_d;
        end
    end

    // In ST_SAT a non-terminal y means the direction has reversed, so stepping leaves saturation.
    always_comb begin
        y_d       = y;
        state_d   = state;
        wrapped_d = 1'b0;
        if (clear) begin
            y_d     = '0;
            state_d = ST_RUN;
        end else if (load) begin
            y_d     = load_clamped;
            state_d = ST_RUN;
        end else if (en) begin
            case (state)
                ST_RUN: begin
                    if (at_terminal && SAT_EN) begin
                        state_d = ST_SAT;
                    end else begin
                        y_d       = y_step;
                        wrapped_d = wrap_event;
                    end
                end
                ST_SAT: begin
                    if (!at_terminal) begin
                        y_d     = y_step;
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_mod_n.sv
// Self-checking bench: three counter configurations sharing one set of controls.
module tb_counter_mod_n;
    import counter_pkg::*;

    logic       clk = 1'b0;
    logic       reset, en, up, clear, load;
    logic [3:0] load_val;
    logic [1:0] y_a, y_c;
    logic [3:0] y_b;
    logic       tc_a, tc_b, tc_c;
    logic       wr_a, wr_b, wr_c;
    logic       sat_a, sat_b, sat_c;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [3:0] y;
        logic       wr;
        logic       sat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    counter_mod_n #(.WIDTH(2), .MODULUS(4), .SATURATE(0)) u_a (
        .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(load_val[1:0]), .y(y_a), .tc(tc_a), .wrapped(wr_a), .sat(sat_a)
    );

    counter_mod_n #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_b (
        .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(load_val), .y(y_b), .tc(tc_b), .wrapped(wr_b), .sat(sat_b)
    );

    counter_mod_n #(.WIDTH(2), .MODULUS(4), .SATURATE(1)) u_c (
        .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(load_val[1:0]), .y(y_c), .tc(tc_c), .wrapped(wr_c), .sat(sat_c)
    );

    task automatic test_reset();
        exp_t       e;
        logic [3:0] m, prev;
        reset = 1'b0; en = 1'b0; up = 1'b1; clear = 1'b0; load = 1'b0; load_val = 4'd0;
        #12;
        vectors++; if (y_a !== 2'd0)  begin miscompares++; $display("[TB] FAIL reset_y: got %0d want 0", y_a); end
        vectors++; if (wr_a !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wrapped: got %b want 0", wr_a); end
        vectors++; if (sat_c !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_sat: got %b want 0", sat_c); end
        @(negedge clk);
        reset = 1'b1; en = 1'b1; up = 1'b1;
        m = 4'd0;
        for (int i = 0; i < 2; i++) begin
            m = m + 4'd1;
            sb.push_back('{m, 1'b0, 1'b0});
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            vectors++; if ({2'b00, y_a} !== e.y) begin miscompares++; $display("[TB] FAIL pre_reset_count[%0d]: got %0d want %0d", i, y_a, e.y); end
        end
        @(negedge clk); #1;
        reset = 1'b0; #1;
        vectors++; if (y_a !== 2'd0)  begin miscompares++; $display("[TB] FAIL async_reset_y: got %0d want 0", y_a); end
        vectors++; if (wr_a !== 1'b0) begin miscompares++; $display("[TB] FAIL async_reset_wrapped: got %b want 0", wr_a); end
        #1 reset = 1'b1;
        m = 4'd0;
        for (int i = 0; i < 5; i++) begin
            prev = m;
            m    = (m == 4'd3) ? 4'd0 : m + 4'd1;
            sb.push_back('{m, (prev == 4'd3), 1'b0});
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            vectors++; if ({2'b00, y_a} !== e.y) begin miscompares++; $display("[TB] FAIL legacy_seq_y[%0d]: got %0d want %0d", i, y_a, e.y); end
            vectors++; if (wr_a !== e.wr) begin miscompares++; $display("[TB] FAIL legacy_seq_wrapped[%0d]: got %b want %b", i, wr_a, e.wr); end
        end
    endtask

    task automatic test_down_wrap();
        exp_t       e;
        logic [3:0] m, prev, cur;
        @(negedge clk);
        load = 1'b1; load_val = 4'd0; en = 1'b0; clear = 1'b0;
        @(posedge clk); #1;
        vectors++; if (y_b !== 4'd0) begin miscompares++; $display("[TB] FAIL down_load0: got %0d want 0", y_b); end
        @(negedge clk);
        load = 1'b0; en = 1'b1; up = 1'b0;
        m = 4'd0;
        for (int i = 0; i < 12; i++) begin
            prev = m;
            m    = (m == 4'd0) ? 4'd9 : m - 4'd1;
            sb.push_back('{m, (prev == 4'd0), 1'b0});
        end
        cur = 4'd0;
        for (int i = 0; i < 12; i++) begin
            #1;
            vectors++; if (tc_b !== (cur == 4'd0)) begin miscompares++; $display("[TB] FAIL down_tc[%0d]: got %b want %b", i, tc_b, (cur == 4'd0)); end
            @(posedge clk); #1;
            e = sb.pop_front();
            vectors++; if (y_b !== e.y)   begin miscompares++; $display("[TB] FAIL down_y[%0d]: got %0d want %0d", i, y_b, e.y); end
            vectors++; if (wr_b !== e.wr) begin miscompares++; $display("[TB] FAIL down_wrapped[%0d]: got %b want %b", i, wr_b, e.wr); end
            cur = e.y;
            @(negedge clk);
        end
        load = 1'b1; load_val = 4'd12;
        @(posedge clk); #1;
        vectors++; if (y_b !== 4'd9)   begin miscompares++; $display("[TB] FAIL load_clamp: got %0d want 9", y_b); end
        vectors++; if (sat_b !== 1'b0) begin miscompares++; $display("[TB] FAIL wrap_mode_sat: got %b want 0", sat_b); end
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_saturate();
        exp_t       e;
        logic [3:0] m, cur;
        logic       s;
        @(negedge clk);
        clear = 1'b1; en = 1'b0; load = 1'b0; up = 1'b1;
        @(posedge clk); #1;
        vectors++; if (y_c !== 2'd0 || sat_c !== 1'b0) begin miscompares++; $display("[TB] FAIL sat_clear: got y=%0d sat=%b want y=0 sat=0", y_c, sat_c); end
        @(negedge clk);
        clear = 1'b0; en = 1'b1; up = 1'b1;
        m = 4'd0; s = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (!s) begin
                if (m == 4'd3) s = 1'b1;
                else           m = m + 4'd1;
            end
            sb.push_back('{m, 1'b0, s});
        end
        cur = 4'd0;
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++; if (tc_c !== (cur == 4'd3)) begin miscompares++; $display("[TB] FAIL sat_tc[%0d]: got %b want %b", i, tc_c, (cur == 4'd3)); end
            @(posedge clk); #1;
            e = sb.pop_front();
            vectors++; if ({2'b00, y_c} !== e.y) begin miscompares++; $display("[TB] FAIL sat_y[%0d]: got %0d want %0d", i, y_c, e.y); end
            vectors++; if (sat_c !== e.sat) begin miscompares++; $display("[TB] FAIL sat_flag[%0d]: got %b want %b", i, sat_c, e.sat); end
            vectors++; if (wr_c !== 1'b0)   begin miscompares++; $display("[TB] FAIL sat_wrapped[%0d]: got %b want 0", i, wr_c); end
            cur = e.y;
            @(negedge clk);
        end
        up = 1'b0;
        sb.push_back('{4'd2, 1'b0, 1'b0});
        @(posedge clk); #1;
        e = sb.pop_front();
        vectors++; if ({2'b00, y_c} !== e.y) begin miscompares++; $display("[TB] FAIL sat_exit_y: got %0d want %0d", y_c, e.y); end
        vectors++; if (sat_c !== e.sat) begin miscompares++; $display("[TB] FAIL sat_exit_flag: got %b want %b", sat_c, e.sat); end
    endtask

    task automatic test_priority();
        @(negedge clk);
        clear = 1'b1; load = 1'b1; load_val = 4'd2; en = 1'b1; up = 1'b1;
        @(posedge clk); #1;
        vectors++; if (y_a !== 2'd0) begin miscompares++; $display("[TB] FAIL clear_over_load_a: got %0d want 0", y_a); end
        vectors++; if (y_b !== 4'd0) begin miscompares++; $display("[TB] FAIL clear_over_load_b: got %0d want 0", y_b); end
        @(negedge clk);
        clear = 1'b0;
        @(posedge clk); #1;
        vectors++; if (y_a !== 2'd2) begin miscompares++; $display("[TB] FAIL load_over_en_a: got %0d want 2", y_a); end
        vectors++; if (y_b !== 4'd2) begin miscompares++; $display("[TB] FAIL load_over_en_b: got %0d want 2", y_b); end
    endtask

    task automatic test_hold();
        @(negedge clk);
        load = 1'b1; load_val = 4'd3; en = 1'b1; up = 1'b1; clear = 1'b0;
        @(posedge clk); #1;
        vectors++; if (y_a !== 2'd3) begin miscompares++; $display("[TB] FAIL hold_load: got %0d want 3", y_a); end
        @(negedge clk);
        load = 1'b0; en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++; if (tc_a !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_tc[%0d]: got %b want 0", i, tc_a); end
            @(posedge clk); #1;
            vectors++; if (y_a !== 2'd3)  begin miscompares++; $display("[TB] FAIL hold_y[%0d]: got %0d want 3", i, y_a); end
            vectors++; if (wr_a !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_wrapped[%0d]: got %b want 0", i, wr_a); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_sat();
        @(negedge clk);
        load = 1'b1; load_val = 4'd3; en = 1'b1; up = 1'b1; clear = 1'b0;
        @(posedge clk); #1;
        vectors++; if (y_c !== 2'd3 || sat_c !== 1'b0) begin miscompares++; $display("[TB] FAIL midsat_load: got y=%0d sat=%b want y=3 sat=0", y_c, sat_c); end
        @(negedge clk);
        load = 1'b0;
        @(posedge clk); #1;
        vectors++; if (sat_c !== 1'b1) begin miscompares++; $display("[TB] FAIL midsat_enter: got %b want 1", sat_c); end
        @(negedge clk); #1;
        reset = 1'b0; #1;
        vectors++; if (sat_c !== 1'b0) begin miscompares++; $display("[TB] FAIL midsat_reset_sat: got %b want 0", sat_c); end
        vectors++; if (y_c !== 2'd0)   begin miscompares++; $display("[TB] FAIL midsat_reset_y: got %0d want 0", y_c); end
        #1 reset = 1'b1;
        en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_down_wrap();
        test_saturate();
        test_priority();
        test_hold();
        test_reset_mid_sat();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/counter_mod_n.md
Name: counter_mod_n

Overview:
- Parametrised modulo-N up/down counter FSM; next generation of the team's fixed 4-state counter.
- Adds width/modulus generics, enable, direction, synchronous clear and load, and a terminal-count output.
- Adds a wrap-pulse output and an optional saturating mode.
- Used as a sequencer/divider building block in the fsm library.

Parameters:
WIDTH, 2, bit width of count value y
MODULUS, 4, number of count states (0..MODULUS-1); legal range 2 <= MODULUS <= 2**WIDTH
SATURATE, 0, 0 = wrap at terminal value, 1 = stop at terminal value and enter saturated state

Ports:
clk  input  1  clock, rising-edge active
reset  input  1  asynchronous, active-low reset (reset==0 resets)
en  input  1  count enable; counter advances one step per clk while en==1
up  input  1  direction: 1 = increment, 0 = decrement
clear  input  1  synchronous clear to 0
load  input  1  synchronous load of load_val
load_val  input  WIDTH  value to load; clamped to MODULUS-1 if >= MODULUS
y  output  WIDTH  current count, registered
tc  output  1  terminal count, combinational: en==1 and y at terminal for current direction (MODULUS-1 if up, 0 if down)
wrapped  output  1  registered one-cycle pulse, high in the cycle after a wrap event
sat  output  1  high while FSM is in ST_SAT (always 0 when SATURATE==0)

Behaviour:
- Reset: asynchronous assertion when reset falls, independent of clk. Sets y=0, wrapped=0, state=ST_RUN, sat=0.
- Reset release: first count may occur on the first rising clk edge with reset==1.
- Reset mid-operation: any count, load or saturation is abandoned immediately.
- Per-edge priority: clear > load > en > hold.
- clear: y<=0, state<=ST_RUN, wrapped<=0. Ignores en, up and load.
- load: y<=min(load_val, MODULUS-1), state<=ST_RUN, wrapped<=0.
- Count, state ST_RUN, en==1, up==1: y<MODULUS-1 -> y<=y+1; y==MODULUS-1 -> see terminal rules.
- Count, state ST_RUN, en==1, up==0: y>0 -> y<=y-1; y==0 -> see terminal rules.
- Terminal, SATURATE==0: up wraps to 0, down wraps to MODULUS-1; wrapped<=1 for exactly one cycle.
- Terminal, SATURATE==1: y holds; state<=ST_SAT; wrapped stays 0.
- ST_SAT, en==1, direction away from terminal (down after saturating at MODULUS-1, up after saturating at 0): y steps one away, state<=ST_RUN.
- ST_SAT, en==1, same direction: y holds, state stays ST_SAT.
- ST_SAT exits only via clear, load, reset or direction reversal with en==1.
- en==0: y, state hold; wrapped<=0.
- wrapped is 0 on every edge that does not wrap.
- Arithmetic: all computation at WIDTH bits. Never produces y>=MODULUS, including when MODULUS<2**WIDTH (e.g. WIDTH=4, MODULUS=10).
- Latency: y changes one clk after the controlling input is sampled. tc is same-cycle combinational; wrapped is one cycle after.
- Default parameters (WIDTH=2, MODULUS=4, SATURATE=0, en=1, up=1) reproduce the legacy 0,1,2,3,0 sequence.
- Illegal MODULUS (<2 or >2**WIDTH): elaboration-time $error.

Decomposition:
- Package counter_pkg: typedef enum logic {ST_RUN, ST_SAT} counter_state_t.
- counter_pkg also holds constants DIR_UP=1'b1 and DIR_DOWN=1'b0.
- Sub-module counter_next (combinational): inputs y, up; outputs next value, at_terminal, wrap_event. Parameterised by WIDTH, MODULUS.
- Top holds the state register, priority logic and the wrapped register.

Test Plan:
- Async reset: default params, count to y=2, drop reset between edges -> y==0 and wrapped==0 immediately, before the next clk. Release, 5 edges with en=1,up=1 -> y=1,2,3,0,1; wrapped high only after the 3->0 edge.
- Down wrap: WIDTH=4, MODULUS=10, load load_val=0, en=1, up=0 -> y=9,8,...; tc==1 while y==0. Loading load_val=12 -> y==9.
- Saturate: SATURATE=1, MODULUS=4, up from 0 -> y=1,2,3,3,3; sat rises on the edge after reaching 3; wrapped never 1. Set up=0 -> y=2, sat==0.
- Priority: clear=1, load=1, load_val=2, en=1 on the same edge -> y==0. Then load=1 with en=1 -> y==2, no increment.
- Hold: en=0 for 4 cycles at y=3 -> y stays 3, tc==0, wrapped==0.
- Reset mid-saturation: in ST_SAT, assert reset -> sat==0 and y==0 asynchronously.
